// File: rtl/fwrisc_shift_seq.sv
// Multi-cycle RV32 shift sequencer: iterates the single-bit ALU shift once per clock.
// Optional abort input enabled by defining FWRISC_SHIFT_KILL_EN.
`ifndef OP_SLL
`define OP_SLL 3'd4
`endif
`ifndef OP_SRL
`define OP_SRL 3'd5
`endif
`ifndef OP_SRA
`define OP_SRA 3'd6
`endif

module fwrisc_shift_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [31:0] in_data,
    input  logic [4:0]  in_shamt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] alu_op_a,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_out
`ifdef FWRISC_SHIFT_KILL_EN
    ,
    input  logic        kill
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    function automatic logic is_shift_op(input logic [2:0] op);
        logic res;
        case (op)
            `OP_SLL: res = 1'b1;
            `OP_SRL: res = 1'b1;
            `OP_SRA: res = 1'b1;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    logic [1:0]  r_state;
    logic [31:0] r_acc;
    logic [2:0]  r_op;
    logic [4:0]  r_cnt;

    logic [1:0]  w_state_nxt;
    logic [31:0] w_acc_nxt;
    logic [2:0]  w_op_nxt;
    logic [4:0]  w_cnt_nxt;
    logic        w_kill;

`ifdef FWRISC_SHIFT_KILL_EN
    assign w_kill = kill;
`else
    assign w_kill = 1'b0;
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out_data  = r_acc;
    assign alu_op_a  = r_acc;
    assign alu_op    = r_op;

    // Next-state and datapath selection for the sequencer
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_op_nxt    = r_op;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_acc_nxt = in_data;
                    w_op_nxt  = in_op;
                    w_cnt_nxt = in_shamt;
                    // Zero amount or non-shift op: pass the operand straight through
                    if ((in_shamt == 5'd0) || !is_shift_op(in_op)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_kill) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_acc_nxt = alu_out;
                    if (r_cnt != 5'd0) begin
                        w_cnt_nxt = r_cnt - 5'd1;
                    end else begin
                        w_cnt_nxt = 5'd0;
                    end
                    if (r_cnt <= 5'd1) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                if (w_kill || out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and working registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_acc   <= 32'h0000_0000;
            r_op    <= 3'b000;
            r_cnt   <= 5'd0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_op    <= w_op_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fwrisc_shift_seq.sv
// Directed self-checking bench for fwrisc_shift_seq with a behavioural one-bit ALU.
`ifndef OP_SLL
`define OP_SLL 3'd4
`endif
`ifndef OP_SRL
`define OP_SRL 3'd5
`endif
`ifndef OP_SRA
`define OP_SRA 3'd6
`endif

module tb_fwrisc_shift_seq;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [31:0] alu_op_a;
    logic [2:0]  alu_op;
    logic [31:0] alu_out;
`ifdef FWRISC_SHIFT_KILL_EN
    logic        kill;
`endif

    int total;
    int bad;

    fwrisc_shift_seq dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .alu_op_a  (alu_op_a),
        .alu_op    (alu_op),
        .alu_out   (alu_out)
`ifdef FWRISC_SHIFT_KILL_EN
        ,
        .kill      (kill)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-bit shifter standing in for fwrisc_alu
    always_comb begin
        case (alu_op)
            `OP_SLL: alu_out = {alu_op_a[30:0], 1'b0};
            `OP_SRL: alu_out = {1'b0, alu_op_a[31:1]};
            `OP_SRA: alu_out = {alu_op_a[31], alu_op_a[31:1]};
            default: alu_out = alu_op_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issue one request, wait for out_valid, check latency and result
    task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] data,
                           input logic [4:0] shamt, input int exp_lat, input logic [31:0] exp_data);
        int n;
        in_valid = 1'b1;
        in_op    = op;
        in_data  = data;
        in_shamt = shamt;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_data"}, out_data, exp_data);
        check({tag, "_inrdy"}, {31'd0, in_ready}, 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_data   = 32'd0;
        in_shamt  = 5'd0;
        out_ready = 1'b1;
`ifdef FWRISC_SHIFT_KILL_EN
        kill      = 1'b0;
`endif
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'h0000_0000);
        check("rst_alu_op_a", alu_op_a, 32'h0000_0000);
        check("rst_alu_op", {29'd0, alu_op}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        run_req("sll31", `OP_SLL, 32'h0000_0001, 5'd31, 32, 32'h8000_0000);
        check("sll31_op", {29'd0, alu_op}, {29'd0, `OP_SLL});
        tick();
        check("sll31_idle", {31'd0, in_ready}, 32'd1);
        check("sll31_vdrop", {31'd0, out_valid}, 32'd0);

        run_req("sra4", `OP_SRA, 32'h8000_0000, 5'd4, 5, 32'hF800_0000);
        tick();
        run_req("srl4", `OP_SRL, 32'h8000_0000, 5'd4, 5, 32'h0800_0000);
        tick();
        run_req("sh0", `OP_SRA, 32'hDEAD_BEEF, 5'd0, 1, 32'hDEAD_BEEF);
        tick();
        run_req("nonshift", 3'd0, 32'hDEAD_BEEF, 5'd7, 1, 32'hDEAD_BEEF);
        tick();

        // Back-pressure with a stray request during SHIFT
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = `OP_SLL;
        in_data   = 32'h0000_0001;
        in_shamt  = 5'd3;
        tick();
        in_data   = 32'h1234_5678;
        in_shamt  = 5'd0;
        check("bp_shift_inrdy", {31'd0, in_ready}, 32'd0);
        tick();
        in_valid  = 1'b0;
        tick();
        tick();
        check("bp_done_valid", {31'd0, out_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_data", out_data, 32'h0000_0008);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_hold_inrdy", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_idle", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("bp_no_stray", {31'd0, out_valid}, 32'd0);

        // Reset mid-SHIFT discards the pending result
        in_valid = 1'b1;
        in_op    = `OP_SLL;
        in_data  = 32'h0000_0001;
        in_shamt = 5'd20;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid_busy", {31'd0, in_ready}, 32'd0);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_inrdy", {31'd0, in_ready}, 32'd1);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", out_data, 32'h0000_0000);
        #1 reset = 1'b0;
        tick();
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);
        run_req("srl_f0", `OP_SRL, 32'h0000_00F0, 5'd4, 5, 32'h0000_000F);
        tick();

`ifdef FWRISC_SHIFT_KILL_EN
        in_valid = 1'b1;
        in_op    = `OP_SLL;
        in_data  = 32'h0000_0001;
        in_shamt = 5'd10;
        tick();
        in_valid = 1'b0;
        tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_shift_idle", {31'd0, in_ready}, 32'd1);
        check("kill_shift_valid", {31'd0, out_valid}, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        check("kill_shift_novalid", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        run_req("kill_done", `OP_SLL, 32'h0000_0001, 5'd2, 3, 32'h0000_0004);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_done_valid", {31'd0, out_valid}, 32'd0);
        check("kill_done_idle", {31'd0, in_ready}, 32'd1);
        check("kill_done_acc", out_data, 32'h0000_0004);
        out_ready = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwrisc_shift_seq.md
# fwrisc_shift_seq

Multi-cycle shift sequencer in front of `fwrisc_alu`. The ALU shifts by exactly one bit per operation, so this block accepts a full RV32 shift request (SLL/SRL/SRA, 5-bit amount). It iterates the ALU's single-bit shift once per clock by feeding each ALU result back as the next `op_a`. It then returns the final 32-bit result to the writeback path with a valid/ready handshake.

## Interface
- No parameters. Op encodings are `` `OP_SLL ``, `` `OP_SRL `` and `` `OP_SRA `` from `fwrisc_defines.vh`.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `in_op`  in  3  shift op.
- `in_data`  in  32  value to shift.
- `in_shamt`  in  5  shift amount, 0..31.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  32  shifted result.
- `alu_op_a`  out  32  to ALU `op_a`.
- `alu_op`  out  3  to ALU `op`.
- `alu_out`  in  32  from ALU `out`.
- `kill`  in  1  abort. Present only with `FWRISC_SHIFT_KILL_EN`.

## Operation
- Registers:
  - `acc[31:0]`: working value.
  - `op_r[2:0]`: latched op.
  - `cnt[4:0]`: remaining shifts.
  - `state` ∈ {IDLE, SHIFT, DONE}.
- Continuous outputs: `alu_op_a = acc`, `alu_op = op_r`, `out_data = acc`.
- Decoded outputs: `in_ready = (state==IDLE)`, `out_valid = (state==DONE)`.
- IDLE:
  - Accept when `in_valid`. Load `acc<=in_data`, `op_r<=in_op`, `cnt<=in_shamt`.
  - Next state is DONE if `in_shamt==0` or `in_op` is not SLL/SRL/SRA; otherwise SHIFT.
  - A non-shift op passes `in_data` through unchanged.
- SHIFT:
  - Each clock: `acc<=alu_out`, `cnt<=cnt-1`.
  - When `cnt==1`, the final shift is captured and the next state is DONE.
  - `cnt` never wraps below 0.
- DONE:
  - Hold `acc` stable.
  - On `out_valid && out_ready`, go to IDLE.
  - While `out_ready` is low, remain in DONE. `out_data` does not change.
- `in_valid` outside IDLE is ignored; the request is not consumed.
- No bypass: a new request cannot be accepted in the same cycle DONE completes.
- Shift semantics are entirely the ALU's:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA replicates bit 31 every step.

## Timing
- Reset (async):
  - state=IDLE, `acc=0`, `op_r=3'b000`, `cnt=0`.
  - Hence `in_ready=1`, `out_valid=0`, `out_data=0`, `alu_op_a=0`, `alu_op=0`.
- Latency, counted from the accepting edge to `out_valid` high:
  - N+1 clocks for `shamt=N≥1`.
  - 1 clock for `shamt=0` or a non-shift op.
- Throughput: one request per N+2 clocks minimum, including the DONE→IDLE cycle.
- ALU path is combinational within one cycle: `acc`→ALU→`alu_out`→`acc`. No extra pipeline stage.
- Reset asserted mid-SHIFT or in DONE: immediate return to IDLE. The pending result is discarded and no `out_valid` is produced.

## Configuration
- `FWRISC_SHIFT_KILL_EN` defined:
  - The `kill` port exists.
  - `kill` high in SHIFT or DONE forces IDLE at the next edge. `out_valid` then drops (DONE) or never rises (SHIFT). `acc` is left unchanged.
  - `kill` in IDLE has no effect; acceptance proceeds normally.
  - `kill` has priority over `out_ready` in DONE.
- `FWRISC_SHIFT_KILL_EN` undefined:
  - No `kill` port.
  - Requests always run to completion unless reset.

## Test plan
- SLL, `in_data=0x0000_0001`, `shamt=31`, `out_ready=1` → `out_valid` 32 clocks after accept, `out_data=0x8000_0000`, then `in_ready` the next cycle.
- SRA `0x8000_0000`, shamt 4 → `0xF800_0000` after 5 clocks. SRL with same inputs → `0x0800_0000`.
- Shamt 0, `in_data=0xDEAD_BEEF`, any shift op → `out_valid` 1 clock after accept, `out_data=0xDEAD_BEEF`. Same result for a non-shift op with shamt 7.
- Back-pressure:
  - Stimulus: SLL `0x1`, shamt 3, `out_ready` low for 3 cycles in DONE, then high.
  - Required: `out_data=0x8` held stable; `in_ready=0` throughout; IDLE one edge after `out_ready` rises.
  - Also: `in_valid` pulsed during SHIFT is not accepted.
- Reset asserted mid-SHIFT (SLL shamt 20, reset at cycle 5) → asynchronously `in_ready=1`, `out_valid=0`, `out_data=0`. A following SRL `0xF0`, shamt 4 yields `0x0F`.
- With `FWRISC_SHIFT_KILL_EN`:
  - `kill` at SHIFT cycle 2 of a shamt-10 request → IDLE next edge, no `out_valid`.
  - `kill` in DONE with `out_ready=0` → `out_valid` drops next edge.
